// File: rtl/spe_integrate_if.sv
// Router <-> spiking PE packet channels: one inbound, one outbound, each a
// valid/ready handshake carrying a 33-bit packet {dest[3:0], opcode[3:0], data[24:0]}.
interface spe_integrate_if;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;

  // PE side: consumes the inbound channel, produces the outbound one
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Router side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/spe_integrate.sv
// Spiking PE integrate stage: accumulates partial sums for one output neuron,
// fetches the previous membrane residue from the output memory in timestep 2,
// thresholds the potential and stores {residue, spike} back.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ACC       | accepting psums / timestep-done from the router
// REQ       | issuing the residue read request to the output memory
// WAIT_RESP | waiting for the residue response (psums are held off)
// COMPUTE   | one cycle: potential = acc + prev residue, threshold test
// SEND      | presenting the store packet until the router takes it
module spe_integrate #(
  parameter int SPE_ID    = 0,
  parameter int OMEM_ID   = 11,
  parameter int NUM_PSUMS = 5,
  parameter int THRESHOLD = 64
) (
  input  logic                clk,
  input  logic                reset,
  spe_integrate_if.slave      bus,
  output logic [1:0]          ts,
  output logic [8:0]          neuron_cnt,
  output logic                proto_err
);

  localparam int          CNT_W     = $clog2(NUM_PSUMS + 1);
  localparam logic [3:0]  OP_PSUM   = 4'd12;
  localparam logic [3:0]  OP_TSDONE = 4'd15;
  localparam logic [3:0]  OP_STORE  = 4'(2 * SPE_ID);
  localparam logic [3:0]  OP_REQ    = 4'(2 * SPE_ID + 1);
  localparam logic [3:0]  OMEM_ADDR = 4'(OMEM_ID);
  localparam logic [12:0] THR       = 13'(THRESHOLD);
  localparam logic [12:0] SAT_MAX   = 13'h1FFF;

  typedef enum logic [2:0] {
    ST_ACC,
    ST_REQ,
    ST_WAIT_RESP,
    ST_COMPUTE,
    ST_SEND
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [12:0]        r_acc;
  logic [CNT_W-1:0]   r_psum_cnt;
  logic [12:0]        r_prev;
  logic [12:0]        r_residue;
  logic               r_spike;
  logic [1:0]         r_ts;
  logic [8:0]         r_neuron_cnt;
  logic               r_proto_err;

  logic               w_in_ready;
  logic               w_out_valid;
  logic [32:0]        w_out_data;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic [3:0]         w_opcode;
  logic [12:0]        w_psum;
  logic               w_last_psum;
  logic [13:0]        w_acc_sum;
  logic [12:0]        w_acc_sat;
  logic [13:0]        w_pot_sum;
  logic [12:0]        w_pot;
  logic               w_unused_bits;

  assign w_opcode      = bus.in_data[28:25];
  assign w_psum        = bus.in_data[12:0];
  assign w_unused_bits = ^{bus.in_data[32:29], bus.in_data[24:14]};
  assign w_in_xfer     = bus.in_valid && w_in_ready;
  assign w_out_xfer    = w_out_valid && bus.out_ready;
  assign w_last_psum   = (r_psum_cnt == CNT_W'(NUM_PSUMS - 1));

  // Both sums are unsigned 13-bit with one carry bit; a set carry clamps to max
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_psum};
  assign w_acc_sat = w_acc_sum[13] ? SAT_MAX : w_acc_sum[12:0];
  assign w_pot_sum = {1'b0, r_acc} + {1'b0, r_prev};
  assign w_pot     = w_pot_sum[13] ? SAT_MAX : w_pot_sum[12:0];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign ts            = r_ts;
  assign neuron_cnt    = r_neuron_cnt;
  assign proto_err     = r_proto_err;

  // State register; reset drops any in-flight packet straight back to ACC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_ACC;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs, decoded from state so reset acts at once
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_data  = '0;
    case (r_state)
      ST_ACC: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (w_opcode == OP_PSUM) && w_last_psum)
          w_state_nxt = (r_ts == 2'd2) ? ST_REQ : ST_COMPUTE;
      end
      ST_REQ: begin
        w_out_valid = 1'b1;
        w_out_data  = {OMEM_ADDR, OP_REQ, 25'd0};
        if (bus.out_ready) w_state_nxt = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        w_in_ready = bus.in_valid && (w_opcode != OP_PSUM);
        if (w_in_ready) w_state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_out_valid = 1'b1;
        w_out_data  = {OMEM_ADDR, OP_STORE, 11'd0, r_residue, r_spike};
        if (bus.out_ready) w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Datapath: accumulation, residue fetch, threshold and timestep bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc        <= '0;
      r_psum_cnt   <= '0;
      r_prev       <= '0;
      r_residue    <= '0;
      r_spike      <= 1'b0;
      r_ts         <= 2'd1;
      r_neuron_cnt <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_in_xfer) begin
            if (w_opcode == OP_PSUM) begin
              r_acc      <= w_acc_sat;
              r_psum_cnt <= r_psum_cnt + 1'b1;
              // Timestep 1 has no stored residue to fetch
              if (w_last_psum && (r_ts == 2'd1)) r_prev <= '0;
            end else if (w_opcode == OP_TSDONE) begin
              r_ts         <= 2'd2;
              r_neuron_cnt <= '0;
              r_acc        <= '0;
              r_psum_cnt   <= '0;
              if (r_psum_cnt != '0) r_proto_err <= 1'b1;
            end else begin
              r_proto_err <= 1'b1;
            end
          end
        end
        ST_WAIT_RESP: begin
          if (w_in_xfer) r_prev <= bus.in_data[13:1];
        end
        ST_COMPUTE: begin
          if (w_pot >= THR) begin
            r_spike   <= 1'b1;
            r_residue <= w_pot - THR;
          end else begin
            r_spike   <= 1'b0;
            r_residue <= w_pot;
          end
        end
        ST_SEND: begin
          if (w_out_xfer) begin
            r_neuron_cnt <= r_neuron_cnt + 1'b1;
            r_acc        <= '0;
            r_psum_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spe_integrate.sv
// Scoreboarded bench for spe_integrate with SPE_ID=1 (store op 2, request op 3).
module tb_spe_integrate;

  localparam int SPE_ID = 1;

  typedef int psum_vec_t [5];

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ts;
  logic [8:0] neuron_cnt;
  logic       proto_err;

  spe_integrate_if bus ();

  spe_integrate #(
    .SPE_ID(SPE_ID), .OMEM_ID(11), .NUM_PSUMS(5), .THRESHOLD(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ts         (ts),
    .neuron_cnt (neuron_cnt),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] sb_q [$];
  int          m_ts = 1;
  int          m_ncnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] mk(input int dest, input int op, input int data);
    return {4'(dest), 4'(op), 25'(data)};
  endfunction

  task automatic send_pkt(input logic [32:0] pkt);
    bit ok;
    bit done;
    done = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = pkt;
    for (int i = 0; i < 50; i++) begin
      #1 ok = bus.in_ready;
      @(posedge clk);
      if (ok) begin done = 1; break; end
      @(negedge clk);
    end
    #1 bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic recv_pkt(input string tag, output logic [32:0] data);
    bit got;
    got  = 0;
    data = '0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.out_valid) begin
        data = bus.out_data;
        @(posedge clk);
        got = 1;
        break;
      end
      @(negedge clk);
    end
    #1 bus.out_ready = 1'b0;
    if (!got) check({tag, "_timeout"}, 0, 1);
    else if (sb_q.size() == 0) check({tag, "_unexpected"}, 1, 0);
    else check(tag, data, sb_q.pop_front());
  endtask

  // One neuron: five psums, optional residue fetch (ts2), optional output stall
  task automatic do_neuron(input psum_vec_t ps, input int resp, input int stall,
                           output logic [32:0] store);
    int          acc;
    int          prev;
    int          pot;
    int          spike;
    int          res;
    logic [32:0] tmp;
    logic [32:0] held;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      acc = acc + ps[i];
      if (acc > 8191) acc = 8191;
      send_pkt(mk(1, 12, ps[i]));
    end
    if (m_ts == 1) begin
      prev = 0;
      check("lat_ts1_e1", bus.out_valid, 0);
      @(posedge clk); #1;
      check("lat_ts1_e2", bus.out_valid, 1);
    end else begin
      check("lat_req", bus.out_valid, 1);
      sb_q.push_back(mk(11, 2 * SPE_ID + 1, 0));
      recv_pkt("req_pkt", tmp);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = mk(1, 12, 7);
      for (int k = 0; k < 3; k++) begin
        #1 check("wait_psum_hold", bus.in_ready, 0);
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      prev = (resp >> 1) & 8191;
      send_pkt(mk(1, 5, resp));
      check("lat_resp_e1", bus.out_valid, 0);
      @(posedge clk); #1;
      check("lat_resp_e2", bus.out_valid, 1);
    end
    pot = acc + prev;
    if (pot > 8191) pot = 8191;
    spike = (pot >= 64) ? 1 : 0;
    res   = spike ? pot - 64 : pot;
    sb_q.push_back(mk(11, 2 * SPE_ID, res * 2 + spike));
    if (stall > 0) begin
      held = sb_q[0];
      for (int k = 0; k < stall; k++) begin
        @(negedge clk); #1;
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, held);
      end
    end
    recv_pkt("store_pkt", store);
    m_ncnt = (m_ncnt + 1) % 512;
    check("neuron_cnt", neuron_cnt, m_ncnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] st;
    logic [32:0] tmp;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_ts", ts, 1);
    check("rst_ncnt", neuron_cnt, 0);
    check("rst_perr", proto_err, 0);
    @(negedge clk) reset = 1'b0;

    // ts1 neuron below threshold
    do_neuron('{10, 20, 5, 15, 3}, 0, 0, st);
    check("ts1_below", st, {4'd11, 4'd2, 25'd106});
    // ts1 neuron that fires
    do_neuron('{20, 20, 20, 10, 0}, 0, 0, st);
    check("ts1_spike", st, {4'd11, 4'd2, 25'd13});
    // saturating accumulation with a stalled router
    do_neuron('{4000, 4000, 4000, 4000, 4000}, 0, 5, st);
    check("sat_store", st, {4'd11, 4'd2, 25'd16255});
    #1 check("single_xfer", bus.out_valid, 0);

    // clean timestep done
    send_pkt(mk(1, 15, 0));
    m_ts = 2; m_ncnt = 0;
    #1;
    check("tsdone_ts", ts, 2);
    check("tsdone_ncnt", neuron_cnt, 0);
    check("tsdone_perr", proto_err, 0);

    // ts2 neuron with fetched residue 40
    do_neuron('{10, 5, 5, 5, 5}, 80, 0, st);
    check("ts2_store", st, {4'd11, 4'd2, 25'd13});

    // timestep done mid-neuron discards partial state
    send_pkt(mk(1, 12, 3));
    send_pkt(mk(1, 12, 4));
    send_pkt(mk(1, 15, 0));
    m_ncnt = 0;
    #1;
    check("early_tsdone_perr", proto_err, 1);
    check("early_tsdone_ts", ts, 2);
    check("early_tsdone_ncnt", neuron_cnt, 0);
    do_neuron('{1, 2, 3, 4, 5}, 20, 0, st);
    check("fresh_store", st, {4'd11, 4'd2, 25'd50});

    // reset while the store packet is pending
    for (int i = 0; i < 5; i++) send_pkt(mk(1, 12, 1));
    sb_q.push_back(mk(11, 2 * SPE_ID + 1, 0));
    recv_pkt("req_pkt", tmp);
    send_pkt(mk(1, 5, 0));
    @(posedge clk); #1;
    check("pre_rst_send", bus.out_valid, 1);
    @(negedge clk) reset = 1'b1;
    #1;
    check("rst_send_out_valid", bus.out_valid, 0);
    check("rst_send_out_data", bus.out_data, 0);
    check("rst_send_ts", ts, 1);
    check("rst_send_in_ready", bus.in_ready, 1);
    check("rst_send_perr", proto_err, 0);
    @(negedge clk) reset = 1'b0;
    m_ts = 1; m_ncnt = 0;
    sb_q.delete();

    // stray memory response in ACC
    send_pkt(mk(1, 7, 5));
    #1 check("stray_resp_perr", proto_err, 1);

    // neuron counter wraps 511 -> 0
    for (int n = 0; n < 512; n++) do_neuron('{0, 0, 0, 0, 0}, 0, 0, st);
    check("wrap_ncnt", neuron_cnt, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
